// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the decode/ALU/data-memory slice: ALU codes, immediate and
// writeback selects, RV32I opcodes, plus the funct3/funct7 to ALU-code helpers.
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluAnd  = 4'd2,
        AluOr   = 4'd3,
        AluXor  = 4'd4,
        AluSll  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluSlt  = 4'd8,
        AluSltu = 4'd9,
        AluBeq  = 4'd10,
        AluBne  = 4'd11,
        AluBlt  = 4'd12,
        AluBge  = 4'd13,
        AluBltu = 4'd14,
        AluBgeu = 4'd15
    } alu_op_e;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmU = 3'b011;
    localparam logic [2:0] ImmJ = 3'b100;

    localparam logic [1:0] ResAlu  = 2'b00;
    localparam logic [1:0] ResLoad = 2'b01;
    localparam logic [1:0] ResPc4  = 2'b10;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    // SUB exists only in the register form; funct7[5] on I-type ADDI is immediate data.
    function automatic alu_op_e alu_arith(input logic [2:0] funct3, input logic funct7_5,
                                          input logic is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && funct7_5) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = funct7_5 ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    function automatic alu_op_e alu_branch(input logic [2:0] funct3);
        alu_op_e op;
        case (funct3)
            3'b001:  op = AluBne;
            3'b100:  op = AluBlt;
            3'b101:  op = AluBge;
            3'b110:  op = AluBltu;
            3'b111:  op = AluBgeu;
            default: op = AluBeq;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: arithmetic/logic result plus a compare flag for branch codes.
module alu_core
    import alu_ctrl_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  alu_op_e     alu_op,
    output logic [31:0] result,
    output logic        flag
);

    logic [31:0] diff;
    logic        lt_s;
    logic        lt_u;

    assign diff = op1 - op2;
    assign lt_s = $signed(op1) < $signed(op2);
    assign lt_u = op1 < op2;

    always_comb begin
        result = diff;
        flag   = 1'b0;
        case (alu_op)
            AluAdd:  result = op1 + op2;
            AluSub:  result = diff;
            AluAnd:  result = op1 & op2;
            AluOr:   result = op1 | op2;
            AluXor:  result = op1 ^ op2;
            AluSll:  result = op1 << op2[4:0];
            AluSrl:  result = op1 >> op2[4:0];
            AluSra:  result = $unsigned($signed(op1) >>> op2[4:0]);
            AluSlt:  result = {31'd0, lt_s};
            AluSltu: result = {31'd0, lt_u};
            AluBeq:  flag = (diff == 32'd0);
            AluBne:  flag = (diff != 32'd0);
            AluBlt:  flag = lt_s;
            AluBge:  flag = !lt_s;
            AluBltu: flag = lt_u;
            AluBgeu: flag = !lt_u;
            default: result = diff;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_dmem.sv
// RV32I execute/memory slice: instruction decode, operand muxing, ALU, byte-addressed
// little-endian data memory with combinational reads and clocked stores, and writeback mux.
module alu_ctrl_dmem
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    output logic        reg_write,
    output logic [2:0]  imm_src,
    output logic [1:0]  result_src,
    output logic        branch,
    output logic        jump,
    output logic        jalr_sel,
    output logic        mem_write,
    output logic [2:0]  mem_ctrl,
    output logic [31:0] alu_result,
    output logic        branch_taken,
    output logic [31:0] read_data,
    output logic [31:0] result
);

    localparam int unsigned DmemBytes = 1 << DMEM_ADDR_WIDTH;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rd;
    logic        writes_rd;
    logic [31:0] op1;
    logic [31:0] op2;
    alu_op_e     alu_op;
    logic        alu_flag;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7_5 = instr[30];

    always_comb begin
        writes_rd  = 1'b0;
        imm_src    = ImmI;
        result_src = ResAlu;
        branch     = 1'b0;
        jump       = 1'b0;
        jalr_sel   = 1'b0;
        mem_write  = 1'b0;
        mem_ctrl   = funct3;
        op1        = rs1_data;
        op2        = imm;
        alu_op     = AluAdd;
        case (opcode)
            OpcR: begin
                writes_rd = 1'b1;
                op2       = rs2_data;
                alu_op    = alu_arith(funct3, funct7_5, 1'b1);
            end
            OpcImm: begin
                writes_rd = 1'b1;
                alu_op    = alu_arith(funct3, funct7_5, 1'b0);
            end
            OpcLoad: begin
                writes_rd  = 1'b1;
                result_src = ResLoad;
            end
            OpcStore: begin
                imm_src   = ImmS;
                mem_write = 1'b1;
            end
            OpcBranch: begin
                imm_src = ImmB;
                branch  = 1'b1;
                op2     = rs2_data;
                alu_op  = alu_branch(funct3);
            end
            OpcJal: begin
                writes_rd  = 1'b1;
                imm_src    = ImmJ;
                jump       = 1'b1;
                result_src = ResPc4;
            end
            OpcJalr: begin
                writes_rd  = 1'b1;
                jump       = 1'b1;
                jalr_sel   = 1'b1;
                result_src = ResPc4;
            end
            OpcLui: begin
                writes_rd = 1'b1;
                imm_src   = ImmU;
                op1       = 32'd0;
            end
            OpcAuipc: begin
                writes_rd = 1'b1;
                imm_src   = ImmU;
                op1       = pc;
            end
            default: mem_ctrl = 3'b000;
        endcase
    end

    assign reg_write = writes_rd && (rd != 5'd0);

    alu_core u_alu_core (
        .op1    (op1),
        .op2    (op2),
        .alu_op (alu_op),
        .result (alu_result),
        .flag   (alu_flag)
    );

    assign branch_taken = jump | (branch & alu_flag);

    // Memory is never cleared by rst; contents start at zero.
    logic [7:0] mem [DmemBytes] = '{default: 8'h00};

    logic [DMEM_ADDR_WIDTH-1:0] addr0;
    logic [DMEM_ADDR_WIDTH-1:0] addr1;
    logic [DMEM_ADDR_WIDTH-1:0] addr2;
    logic [DMEM_ADDR_WIDTH-1:0] addr3;
    logic [7:0]                 byte0;
    logic [7:0]                 byte1;
    logic [7:0]                 byte2;
    logic [7:0]                 byte3;

    // Byte lanes wrap within the memory, so misaligned accesses never fault.
    assign addr0 = alu_result[DMEM_ADDR_WIDTH-1:0];
    assign addr1 = addr0 + DMEM_ADDR_WIDTH'(1);
    assign addr2 = addr0 + DMEM_ADDR_WIDTH'(2);
    assign addr3 = addr0 + DMEM_ADDR_WIDTH'(3);

    assign byte0 = mem[addr0];
    assign byte1 = mem[addr1];
    assign byte2 = mem[addr2];
    assign byte3 = mem[addr3];

    always_comb begin
        read_data = {byte3, byte2, byte1, byte0};
        case (funct3)
            3'b000:  read_data = {{24{byte0[7]}}, byte0};
            3'b001:  read_data = {{16{byte1[7]}}, byte1, byte0};
            3'b100:  read_data = {24'd0, byte0};
            3'b101:  read_data = {16'd0, byte1, byte0};
            default: read_data = {byte3, byte2, byte1, byte0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_write) begin
            mem[addr0] <= rs2_data[7:0];
            if (mem_ctrl[1:0] != 2'b00) begin
                mem[addr1] <= rs2_data[15:8];
            end
            if (mem_ctrl[1]) begin
                mem[addr2] <= rs2_data[23:16];
                mem[addr3] <= rs2_data[31:24];
            end
        end
    end

    always_comb begin
        case (result_src)
            ResLoad: result = read_data;
            ResPc4:  result = pc_plus4;
            default: result = alu_result;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{instr[31], instr[29:15], alu_result[31:DMEM_ADDR_WIDTH]};

endmodule

// File: tb/tb_alu_ctrl_dmem.sv
// Directed-vector bench for alu_ctrl_dmem; inputs change on the falling edge so any
// store presented is committed at the following rising edge.
module tb_alu_ctrl_dmem;
    import alu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [31:0] imm = 32'd0;
    logic [31:0] pc = 32'd0;
    logic [31:0] pc_plus4 = 32'd4;
    logic        reg_write;
    logic [2:0]  imm_src;
    logic [1:0]  result_src;
    logic        branch;
    logic        jump;
    logic        jalr_sel;
    logic        mem_write;
    logic [2:0]  mem_ctrl;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] read_data;
    logic [31:0] result;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    alu_ctrl_dmem #(.DMEM_ADDR_WIDTH(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .reg_write    (reg_write),
        .imm_src      (imm_src),
        .result_src   (result_src),
        .branch       (branch),
        .jump         (jump),
        .jalr_sel     (jalr_sel),
        .mem_write    (mem_write),
        .mem_ctrl     (mem_ctrl),
        .alu_result   (alu_result),
        .branch_taken (branch_taken),
        .read_data    (read_data),
        .result       (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        return {f7, 10'd0, f3, rd, op};
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [31:0] p, input logic r);
        @(negedge clk);
        instr    = i;
        rs1_data = r1;
        rs2_data = r2;
        imm      = im;
        pc       = p;
        pc_plus4 = p + 32'd4;
        rst      = r;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with an all-zero (unknown opcode) instruction.
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        check("rst_reg_write", reg_write, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_taken", branch_taken, 0);

        drive(enc(7'h00, 3'b000, 5'd3, OpcR), 32'd5, 32'd7, 32'd0, 32'd0, 1'b0);
        check("add_result", result, 32'd12);
        check("add_reg_write", reg_write, 1);
        drive(enc(7'h00, 3'b000, 5'd3, OpcR), 32'd5, 32'd7, 32'd0, 32'd0, 1'b1);
        check("add_under_rst", result, 32'd12);
        drive(enc(7'h20, 3'b000, 5'd3, OpcR), 32'd5, 32'd7, 32'd0, 32'd0, 1'b0);
        check("sub_result", result, 32'hFFFF_FFFE);
        drive(enc(7'h00, 3'b000, 5'd0, OpcR), 32'd5, 32'd7, 32'd0, 32'd0, 1'b0);
        check("add_x0_reg_write", reg_write, 0);
        drive(enc(7'h00, 3'b100, 5'd3, OpcR), 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0, 1'b0);
        check("xor_result", result, 32'h0000_0FF0);
        drive(enc(7'h00, 3'b010, 5'd3, OpcR), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
        check("slt_result", result, 32'd1);
        drive(enc(7'h00, 3'b011, 5'd3, OpcR), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
        check("sltu_result", result, 32'd0);
        drive(enc(7'h20, 3'b101, 5'd5, OpcImm), 32'h8000_0000, 32'd0, 32'h0000_0404, 32'd0, 1'b0);
        check("srai_result", result, 32'hF800_0000);
        drive(enc(7'h00, 3'b101, 5'd5, OpcImm), 32'h8000_0000, 32'd0, 32'd4, 32'd0, 1'b0);
        check("srli_result", result, 32'h0800_0000);
        drive(enc(7'h20, 3'b000, 5'd5, OpcImm), 32'd10, 32'd0, 32'd3, 32'd0, 1'b0);
        check("addi_f7_ignored", result, 32'd13);

        // Branches
        drive(enc(7'h00, 3'b100, 5'd0, OpcBranch), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
        check("blt_taken", branch_taken, 1);
        check("blt_branch", branch, 1);
        drive(enc(7'h00, 3'b110, 5'd0, OpcBranch), 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0);
        check("bltu_taken", branch_taken, 0);
        drive(enc(7'h00, 3'b000, 5'd0, OpcBranch), 32'd9, 32'd9, 32'd0, 32'd0, 1'b0);
        check("beq_taken", branch_taken, 1);
        check("beq_alu_result", alu_result, 32'd0);
        drive(enc(7'h00, 3'b001, 5'd0, OpcBranch), 32'd9, 32'd9, 32'd0, 32'd0, 1'b0);
        check("bne_taken", branch_taken, 0);

        // Store then load at 0x100
        drive(enc(7'h00, 3'b010, 5'd0, OpcStore), 32'h100, 32'h8040_2010, 32'd0, 32'd0, 1'b0);
        check("sw_mem_write", mem_write, 1);
        check("sw_imm_src", imm_src, {29'd0, ImmS});
        check("sw_reg_write", reg_write, 0);
        drive(enc(7'h00, 3'b000, 5'd7, OpcLoad), 32'h100, 32'd0, 32'd0, 32'd0, 1'b0);
        check("lb_100", result, 32'h0000_0010);
        drive(enc(7'h00, 3'b000, 5'd7, OpcLoad), 32'h100, 32'd0, 32'd3, 32'd0, 1'b0);
        check("lb_103", result, 32'hFFFF_FF80);
        drive(enc(7'h00, 3'b101, 5'd7, OpcLoad), 32'h100, 32'd0, 32'd2, 32'd0, 1'b0);
        check("lhu_102", result, 32'h0000_8040);
        drive(enc(7'h00, 3'b001, 5'd7, OpcLoad), 32'h100, 32'd0, 32'd2, 32'd0, 1'b0);
        check("lh_102", result, 32'hFFFF_8040);

        // Same-cycle store returns old contents, new value visible next cycle.
        drive(enc(7'h00, 3'b010, 5'd0, OpcStore), 32'h100, 32'h1122_3344, 32'd0, 32'd0, 1'b0);
        check("sw_read_old", read_data, 32'h8040_2010);
        drive(enc(7'h00, 3'b010, 5'd7, OpcLoad), 32'h100, 32'd0, 32'd0, 32'd0, 1'b0);
        check("lw_new", result, 32'h1122_3344);
        drive(enc(7'h00, 3'b001, 5'd0, OpcStore), 32'h100, 32'hFFFF_BEEF, 32'd0, 32'd0, 1'b0);
        drive(enc(7'h00, 3'b010, 5'd7, OpcLoad), 32'h100, 32'd0, 32'd0, 32'd0, 1'b0);
        check("sh_partial", result, 32'h1122_BEEF);

        // Misaligned word wrapping past the top of memory.
        drive(enc(7'h00, 3'b010, 5'd0, OpcStore), 32'hFFE, 32'hAABB_CCDD, 32'd0, 32'd0, 1'b0);
        drive(enc(7'h00, 3'b010, 5'd7, OpcLoad), 32'hFFE, 32'd0, 32'd0, 32'd0, 1'b0);
        check("lw_wrap", result, 32'hAABB_CCDD);
        drive(enc(7'h00, 3'b101, 5'd7, OpcLoad), 32'h0, 32'd0, 32'd0, 32'd0, 1'b0);
        check("lhu_wrap_low", result, 32'h0000_AABB);

        // Reset suppresses stores.
        drive(enc(7'h00, 3'b010, 5'd0, OpcStore), 32'h20, 32'd0, 32'd0, 32'd0, 1'b0);
        drive(enc(7'h00, 3'b000, 5'd0, OpcStore), 32'h20, 32'h0000_00AB, 32'd0, 32'd0, 1'b1);
        drive(enc(7'h00, 3'b010, 5'd7, OpcLoad), 32'h20, 32'd0, 32'd0, 32'd0, 1'b0);
        check("sb_under_rst", result, 32'd0);
        drive(enc(7'h00, 3'b000, 5'd0, OpcStore), 32'h20, 32'h0000_00AB, 32'd0, 32'd0, 1'b0);
        drive(enc(7'h00, 3'b010, 5'd7, OpcLoad), 32'h20, 32'd0, 32'd0, 32'd0, 1'b0);
        check("sb_no_rst", result, 32'h0000_00AB);

        // Upper immediates and jumps
        drive(enc(7'h00, 3'b000, 5'd4, OpcLui), 32'hDEAD_BEEF, 32'd0, 32'h1234_5000, 32'd0, 1'b0);
        check("lui_result", result, 32'h1234_5000);
        drive(enc(7'h00, 3'b000, 5'd4, OpcAuipc), 32'hDEAD_BEEF, 32'd0, 32'h1000, 32'h100, 1'b0);
        check("auipc_result", result, 32'h1100);
        drive(enc(7'h00, 3'b000, 5'd1, OpcJal), 32'd0, 32'd0, 32'h40, 32'h100, 1'b0);
        check("jal_result", result, 32'h104);
        check("jal_taken", branch_taken, 1);
        check("jal_reg_write", reg_write, 1);
        drive(enc(7'h00, 3'b000, 5'd1, OpcJalr), 32'h200, 32'd0, 32'd8, 32'h100, 1'b0);
        check("jalr_sel", jalr_sel, 1);
        check("jalr_target", alu_result, 32'h208);
        check("jalr_result", result, 32'h104);

        // Unknown opcode acts as a NOP and must not touch memory.
        drive({25'd0, 7'h7F} | 32'h0000_0080, 32'h20, 32'h0000_0055, 32'd0, 32'd0, 1'b0);
        check("nop_reg_write", reg_write, 0);
        check("nop_mem_write", mem_write, 0);
        check("nop_taken", branch_taken, 0);
        drive(enc(7'h00, 3'b010, 5'd7, OpcLoad), 32'h20, 32'd0, 32'd0, 32'd0, 1'b0);
        check("nop_mem_intact", result, 32'h0000_00AB);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
